code_loader: RTL and testbench
==============================

Name: code_loader

Overview:
- Produces the secret code that the match logic compares guesses against, so it is the writer side of the code path.
- The operator enters four digits, most significant nibble first. For each digit they set the switches and press the pushbutton.
- After the fourth accepted digit the code freezes and lock_o asserts. The code stays frozen until an unlock pulse arrives.
- The block sits between the board switch/pushbutton pins and the code input of the match logic. lock_o drives the board lock output.

Parameters:
- DB_W, 16, width of the debounce counter.
- DEBOUNCE_CYCLES, 50000, number of consecutive cycles pb must hold a new level before that level is accepted. Legal range is 2 to 2^DB_W-1.
- DIGIT_MAX, 9, largest digit value accepted; a larger switch value is rejected.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- sw  input  4  raw switch levels, asynchronous to clk.
- pb  input  1  raw pushbutton, asynchronous, active-high.
- unlock_i  input  1  synchronous single-cycle pulse that clears the code and restarts entry.
- code_o  output  16  entered code; digit 0 is in [15:12], digit 3 is in [3:0].
- digit_idx_o  output  2  index of the next digit to be entered.
- lock_o  output  1  high while the code is complete and frozen.
- code_valid_o  output  1  one-cycle pulse when the fourth digit is accepted.
- err_o  output  1  one-cycle pulse when a press carries a value greater than DIGIT_MAX.
- press_o  output  1  one-cycle debounced press pulse, exposed for debug and verification.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchronizer flops, debounce counter and debounced pb level all go to 0.
  - code_o=0, digit_idx_o=0, lock_o=0, code_valid_o=0, err_o=0, press_o=0.
  - FSM goes to ENTER.
- Reset asserted mid-entry discards any partial code. Release is synchronous to clk, handled externally.
- Synchronizer: pb and sw each pass through 2 flops. All downstream logic uses only the synchronized values.
- Debounce:
  - If synced pb equals the debounced level, the counter is 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synced value and the counter clears.
  - press_o pulses in the cycle after a 0->1 change of the debounced level.
  - Net latency: press_o goes high DEBOUNCE_CYCLES+2 cycles after the first clk edge that samples pb=1.
  - A pb pulse or glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) produces no press.
  - A release never produces a press.
- FSM states: ENTER and LOCKED. A press is consumed in the same cycle press_o is high, so outputs update one cycle later.
- ENTER, press with synced sw > DIGIT_MAX:
  - err_o pulses.
  - code_o and digit_idx_o are unchanged.
- ENTER, press with synced sw <= DIGIT_MAX:
  - The nibble selected by digit_idx_o takes the sw value; index 0 is [15:12].
  - digit_idx_o increments.
  - At index 3: the nibble is written, digit_idx_o wraps to 0, the FSM moves to LOCKED, lock_o=1 and code_valid_o pulses.
- LOCKED:
  - Presses are ignored: no err_o, no change to code_o.
  - sw changes have no effect.
- unlock_i in either state:
  - Next cycle: code_o=0, digit_idx_o=0, lock_o=0, FSM in ENTER.
  - err_o and code_valid_o are suppressed that cycle.
- Simultaneous unlock_i and press: unlock wins and the press is discarded.
- code_o, lock_o and digit_idx_o are registered outputs and never glitch.
- Holding pb down produces only one press. The next press requires a debounced release, then a new debounced press.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset then release. Press with sw=3, 7, 1, 9 in turn, each held 10 cycles and released 10 cycles. Required: digit_idx_o steps 1,2,3,0; code_o=16'h3719; lock_o=1; code_valid_o high for exactly 1 cycle; err_o never asserts.
2. pb high for 3 cycles, then low. Required: no press_o, code_o=0, digit_idx_o=0. Then pb high for 4 or more cycles: press_o goes high exactly 6 cycles after the first sampled high.
3. In ENTER at index 1, press with sw=4'hC. Required: err_o pulses once; code_o and digit_idx_o are unchanged. A following press with sw=5 writes code_o[11:8]=5.
4. LOCKED with code 16'h3719: press with sw=2. Required: code_o stays 16'h3719, no err_o. Then pulse unlock_i: next cycle code_o=0, lock_o=0, digit_idx_o=0.
5. Drive unlock_i in the same cycle as press_o with sw=2 at index 0. Required: code_o=0 and digit_idx_o=0 afterwards.
6. After two digits are entered, assert rst=0 asynchronously mid-cycle. Required: all outputs read 0 immediately without waiting for a clock edge. After release, entry restarts at index 0.

Source files
------------

// File: rtl/code_loader.sv
// Code entry front end: synchronizes and debounces the board switches and pushbutton,
// assembles four BCD digits into a 16-bit code and freezes it until an unlock pulse.
//
// state  | meaning
// ENTER  | accepting digits, digit_idx_o points at the next nibble to write
// LOCKED | code complete and frozen, presses ignored until unlock_i
module code_loader #(
   parameter int DB_W            = 16,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DIGIT_MAX       = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  sw,
   input  logic        pb,
   input  logic        unlock_i,
   output logic [15:0] code_o,
   output logic [1:0]  digit_idx_o,
   output logic        lock_o,
   output logic        code_valid_o,
   output logic        err_o,
   output logic        press_o
);

   typedef enum logic {ENTER = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]      DIG_MAX = 4'(DIGIT_MAX);

   logic            pb_s1, pb_s2;
   logic [3:0]      sw_s1, sw_s2;
   logic [DB_W-1:0] db_cnt;
   logic            db_lvl, db_lvl_q;

   state_t          state, state_nxt;
   logic [15:0]     code_nxt;
   logic [1:0]      idx_nxt;
   logic            err_nxt, valid_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pb_s1 <= 1'b0;
         pb_s2 <= 1'b0;
         sw_s1 <= 4'd0;
         sw_s2 <= 4'd0;
      end else begin
         pb_s1 <= pb;
         pb_s2 <= pb_s1;
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
      end
   end

   // The counter only runs while the synced level disagrees with the accepted one,
   // so any glitch shorter than DEBOUNCE_CYCLES drops it back to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_cnt   <= '0;
         db_lvl   <= 1'b0;
         db_lvl_q <= 1'b0;
         press_o  <= 1'b0;
      end else begin
         db_lvl_q <= db_lvl;
         press_o  <= db_lvl & ~db_lvl_q;
         if (pb_s2 == db_lvl) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_lvl <= pb_s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ENTER;
         code_o       <= 16'd0;
         digit_idx_o  <= 2'd0;
         err_o        <= 1'b0;
         code_valid_o <= 1'b0;
      end else begin
         state        <= state_nxt;
         code_o       <= code_nxt;
         digit_idx_o  <= idx_nxt;
         err_o        <= err_nxt;
         code_valid_o <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (unlock_i) begin
         state_nxt = ENTER;
      end else if (press_o && state == ENTER && sw_s2 <= DIG_MAX && digit_idx_o == 2'd3) begin
         state_nxt = LOCKED;
      end
   end

   // Unlock has priority over a coincident press, which is simply dropped.
   always_comb begin
      code_nxt  = code_o;
      idx_nxt   = digit_idx_o;
      err_nxt   = 1'b0;
      valid_nxt = 1'b0;
      if (unlock_i) begin
         code_nxt = 16'd0;
         idx_nxt  = 2'd0;
      end else if (press_o && state == ENTER) begin
         if (sw_s2 > DIG_MAX) begin
            err_nxt = 1'b1;
         end else begin
            case (digit_idx_o)
               2'd0:    code_nxt[15:12] = sw_s2;
               2'd1:    code_nxt[11:8]  = sw_s2;
               2'd2:    code_nxt[7:4]   = sw_s2;
               default: code_nxt[3:0]   = sw_s2;
            endcase
            idx_nxt   = digit_idx_o + 2'd1;
            valid_nxt = (digit_idx_o == 2'd3);
         end
      end
   end

   assign lock_o = (state == LOCKED);

endmodule

// File: tb/tb_code_loader.sv
// Bench for code_loader: directed scenarios plus random presses, checked against
// a digit-level model of code entry and an arithmetic model of debounce timing.
module tb_code_loader;

   localparam int D   = 4;
   localparam int REL = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sw;
   logic        pb;
   logic        unlock_i;
   logic [15:0] code_o;
   logic [1:0]  digit_idx_o;
   logic        lock_o, code_valid_o, err_o, press_o;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_code;
   int          m_idx;
   logic        m_lock;

   code_loader #(.DB_W(16), .DEBOUNCE_CYCLES(D), .DIGIT_MAX(9)) dut (
      .clk(clk), .rst(rst), .sw(sw), .pb(pb), .unlock_i(unlock_i),
      .code_o(code_o), .digit_idx_o(digit_idx_o), .lock_o(lock_o),
      .code_valid_o(code_valid_o), .err_o(err_o), .press_o(press_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_code = 16'd0;
      m_idx  = 0;
      m_lock = 1'b0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".code"}, 32'(code_o), 32'(m_code));
      check({tag, ".idx"},  32'(digit_idx_o), 32'(m_idx));
      check({tag, ".lock"}, 32'(lock_o), 32'(m_lock));
   endtask

   // pb is sampled high on exactly `hold` edges; a debounced press is expected
   // to show on press_o after edge D+2, i.e. at sample point D+3.
   // unl_at != 0 raises unlock_i for the cycle following sample point unl_at.
   task automatic do_press(input logic [3:0] v, input int hold, input int unl_at);
      int   np, first, ne, nv;
      logic pressed;
      int   exp_err, exp_val;
      np = 0; first = 0; ne = 0; nv = 0;
      exp_err = 0; exp_val = 0;
      pressed = (hold >= D);
      sw = v;
      pb = 1'b1;
      for (int k = 1; k <= hold + REL; k++) begin
         tick();
         if (press_o) begin
            np++;
            if (first == 0) first = k;
         end
         if (err_o) ne++;
         if (code_valid_o) nv++;
         if (k == hold) pb = 1'b0;
         unlock_i = (unl_at != 0 && k == unl_at);
      end
      unlock_i = 1'b0;

      if (pressed) begin
         if (unl_at == D + 3) begin
            model_clear();
         end else begin
            if (!m_lock) begin
               if (v > 4'd9) begin
                  exp_err = 1;
               end else begin
                  m_code[15 - 4*m_idx -: 4] = v;
                  m_idx++;
                  if (m_idx == 4) begin
                     m_idx   = 0;
                     m_lock  = 1'b1;
                     exp_val = 1;
                  end
               end
            end
            if (unl_at > D + 3) model_clear();
         end
      end else if (unl_at != 0) begin
         model_clear();
      end

      check("press_cnt", 32'(np), pressed ? 32'd1 : 32'd0);
      if (pressed) check("press_lat", 32'(first), 32'(D + 3));
      check("err_cnt", 32'(ne), 32'(exp_err));
      check("valid_cnt", 32'(nv), 32'(exp_val));
      check_state("press");
   endtask

   task automatic pulse_unlock();
      unlock_i = 1'b1;
      tick();
      unlock_i = 1'b0;
      model_clear();
      check_state("unlock");
      tick();
   endtask

   initial begin
      int hold, unl, r;
      logic [3:0] v;
      rst = 1'b0; pb = 1'b0; sw = 4'd0; unlock_i = 1'b0;
      model_clear();
      repeat (3) tick();
      check_state("reset");
      check("reset.press", 32'(press_o), 32'd0);
      check("reset.err",   32'(err_o), 32'd0);
      check("reset.valid", 32'(code_valid_o), 32'd0);
      rst = 1'b1;
      tick();

      // full entry
      do_press(4'd3, 10, 0);
      do_press(4'd7, 10, 0);
      do_press(4'd1, 10, 0);
      do_press(4'd9, 10, 0);
      check("t1.code", 32'(code_o), 32'h3719);
      check("t1.lock", 32'(lock_o), 32'd1);

      // locked ignores presses, then unlock
      do_press(4'd2, 10, 0);
      check("t4.code", 32'(code_o), 32'h3719);
      pulse_unlock();

      // short glitch then a minimum-length press
      do_press(4'd5, 3, 0);
      check("t2.code", 32'(code_o), 32'h0000);
      do_press(4'd6, 4, 0);

      // out-of-range digit at index 1, then a valid one
      do_press(4'hC, 10, 0);
      check("t3.idx", 32'(digit_idx_o), 32'd1);
      do_press(4'd5, 10, 0);
      check("t3.nib", 32'(code_o[11:8]), 32'd5);

      // unlock coinciding with the press
      pulse_unlock();
      do_press(4'd2, 10, D + 3);
      check("t5.code", 32'(code_o), 32'h0000);

      // async reset mid-cycle
      do_press(4'd1, 10, 0);
      do_press(4'd2, 10, 0);
      #2;
      rst = 1'b0;
      #1;
      model_clear();
      check_state("arst");
      check("arst.press", 32'(press_o), 32'd0);
      check("arst.err",   32'(err_o), 32'd0);
      check("arst.valid", 32'(code_valid_o), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      do_press(4'd8, 10, 0);
      check("t6.code", 32'(code_o), 32'h8000);

      for (int n = 0; n < 40; n++) begin
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(D, 12);
         v    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         r    = $urandom_range(0, 9);
         if (r == 0)      unl = D + 3;
         else if (r == 1) unl = $urandom_range(D + 6, hold + REL - 1);
         else             unl = 0;
         do_press(v, hold, unl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
